// File: rtl/io_bank_pkg.sv
// io_bank_pkg: shared address map and types for the io_bank MMIO switch/LED
// peripheral.
//   io_addr_t   : 5-bit MMIO word offset
//   IO_SW_BASE  : debounced switch bank i at IO_SW_BASE+i (read-only)
//   IO_STATUS   : sticky change flags, cleared by reading
//   IO_MASK     : IRQ mask (only meaningful with IO_BANK_IRQ_EN)
//   IO_LED_BASE : LED bank i at IO_LED_BASE+i (read/write)
package io_bank_pkg;

   typedef logic [4:0] io_addr_t;

   localparam io_addr_t IO_SW_BASE  = 5'h00;
   localparam io_addr_t IO_STATUS   = 5'h08;
   localparam io_addr_t IO_MASK     = 5'h09;
   localparam io_addr_t IO_LED_BASE = 5'h10;

endpackage

// File: rtl/io_debounce.sv
// io_debounce: one switch bank. 2-FF synchroniser followed by a debounce
// counter; the stable value only follows the synchronised input after it has
// differed from stable for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk     : system clock
//   rst     : synchronous active-low reset
//   din     : raw asynchronous switch pins
//   stable  : debounced value
//   changed : high in the cycle whose rising edge updates stable
module io_debounce
   import io_bank_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] stable,
   output logic             changed
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   // cnt counts cycles already seen different; the edge on which it would
   // reach DEBOUNCE_CYCLES is the edge that commits the new value.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q, stable_q, stable_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      changed  = 1'b0;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = sync2_q;
         cnt_d    = '0;
         changed  = 1'b1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= din;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;

endmodule

// File: rtl/io_bank.sv
// io_bank: memory-mapped switch/LED peripheral with NUM_CH banks of WIDTH bits.
// Optional feature macro: IO_BANK_IRQ_EN adds the IRQ mask register (0x09) and
// the irq output; without it 0x09 reads 0 and status is polled.
// Ports:
//   clk, rst       : system clock, synchronous active-low reset
//   switches       : raw switch pins, bank i at [i]
//   leds           : LED drive, bank i at [i]
//   addr/wdata/we  : MMIO write port (one-cycle strobe)
//   re/rdata/rvalid: MMIO read port, 1-cycle latency, rvalid pulses once
//   irq            : registered OR of (chg & mask), IO_BANK_IRQ_EN only
module io_bank
   import io_bank_pkg::*;
#(
   parameter int NUM_CH          = 2,
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH-1:0][WIDTH-1:0] switches,
   output logic [NUM_CH-1:0][WIDTH-1:0] leds,
   input  io_addr_t                     addr,
   input  logic [31:0]                  wdata,
   input  logic                         we,
   input  logic                         re,
   output logic [31:0]                  rdata,
   output logic                         rvalid
`ifdef IO_BANK_IRQ_EN
   ,output logic                        irq
`endif
);

   logic [NUM_CH-1:0][WIDTH-1:0] sw_stable;
   logic [NUM_CH-1:0]            sw_changed;
   logic [NUM_CH-1:0][WIDTH-1:0] led_q, led_d;
   logic [NUM_CH-1:0]            chg_q, chg_d;
   logic [31:0]                  rdata_q, rdata_d;
   logic                         rvalid_q;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_bank
      io_debounce #(
         .WIDTH           (WIDTH),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
         .clk     (clk),
         .rst     (rst),
         .din     (switches[gi]),
         .stable  (sw_stable[gi]),
         .changed (sw_changed[gi])
      );
   end

`ifdef IO_BANK_IRQ_EN
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic              irq_q;
`endif

   always_comb begin
      led_d   = led_q;
      rdata_d = '0;
      // A new change in the same cycle as the clearing read survives it.
      chg_d   = ((re && addr == IO_STATUS) ? '0 : chg_q) | sw_changed;
`ifdef IO_BANK_IRQ_EN
      mask_d  = mask_q;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
         if (addr == IO_SW_BASE + io_addr_t'(i)) begin
            rdata_d[WIDTH-1:0] = sw_stable[i];
         end
         if (addr == IO_LED_BASE + io_addr_t'(i)) begin
            rdata_d[WIDTH-1:0] = led_q[i];
            if (we) led_d[i] = wdata[WIDTH-1:0];
         end
      end
      if (addr == IO_STATUS) rdata_d[NUM_CH-1:0] = chg_q;
`ifdef IO_BANK_IRQ_EN
      if (addr == IO_MASK) begin
         rdata_d[NUM_CH-1:0] = mask_q;
         if (we) mask_d = wdata[NUM_CH-1:0];
      end
`endif
      if (!re) rdata_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         led_q    <= '0;
         chg_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
`ifdef IO_BANK_IRQ_EN
         mask_q   <= '0;
         irq_q    <= 1'b0;
`endif
      end else begin
         led_q    <= led_d;
         chg_q    <= chg_d;
         rdata_q  <= rdata_d;
         rvalid_q <= re;
`ifdef IO_BANK_IRQ_EN
         mask_q   <= mask_d;
         irq_q    <= |(chg_q & mask_q);
`endif
      end
   end

   assign leds   = led_q;
   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;
`ifdef IO_BANK_IRQ_EN
   assign irq    = irq_q;
`endif

endmodule

// File: doc/io_bank.md
# io_bank

Parametrised memory-mapped switch/LED peripheral. Generalises the fixed two-bank switch/LED I/O of the board top into `NUM_CH` banks of `WIDTH` bits each, adding:
- input synchronisation and debounce
- per-bank sticky change flags
- readable and writable LED registers

It sits on the CPU's MMIO data port beside the UART, and its pins connect directly to board switches and LEDs.

## Interface
Parameters:
- `NUM_CH`, 2: number of switch banks and LED banks, 1..8
- `WIDTH`, 8: bits per bank, 1..32
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required before a switch change is accepted, ≥1

Ports:
- `clk`  in  1  system clock; all logic on the rising edge
- `rst`  in  1  reset, synchronous, active-low
- `switches`  in  NUM_CH×WIDTH  raw asynchronous switch pins, bank i at `[i]`
- `leds`  out  NUM_CH×WIDTH  LED drive, bank i at `[i]`
- `addr`  in  5  MMIO word offset
- `wdata`  in  32  write data
- `we`  in  1  write strobe, one cycle per write
- `re`  in  1  read strobe, one cycle per read
- `rdata`  out  32  read data
- `rvalid`  out  1  read data valid
- `irq`  out  1  change interrupt; present only with `IO_BANK_IRQ_EN`

## Operation
Address map:
- 0x00+i, read: debounced bank i, zero-extended
- 0x08, read: change status; bit i set means bank i changed since the last status read; the read clears it
- 0x09, read/write: IRQ mask, bit i; only with `IO_BANK_IRQ_EN`
- 0x10+i, read/write: LED bank i; writes use `wdata[WIDTH-1:0]`

Input path, per bank:
- 2-FF synchroniser, then debounce: `cnt` resets to 0 whenever the synced value equals `stable`, otherwise increments.
- When `cnt` reaches `DEBOUNCE_CYCLES`, `stable` takes the synced value, `cnt` goes to 0, and `chg[i]` is set.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches `stable`.

Change status:
- If a set of `chg[i]` and a status-read clear fall in the same cycle, the set wins: the read returns the old value and bit i stays 1.

Bus rules:
- An unmapped address, or an index ≥ `NUM_CH`, reads 0; a write there is ignored.
- `we` and `re` asserted together: both are performed; the read returns the pre-write value.
- A write to a read-only register is ignored.

Reset values (rst=0 at a rising edge):
- `leds`=0, `rdata`=0, `rvalid`=0, `irq`=0
- `stable`=0, `chg`=0, `cnt`=0, synchronisers 0, mask=0
- Reset mid-debounce discards the pending change; no flag is set.

## Timing
- Read latency is 1 cycle. `re` sampled at edge k gives `rdata`/`rvalid` valid after edge k; `rvalid` is a single-cycle pulse. Back-to-back reads are allowed every cycle.
- A write at edge k updates `leds` after edge k, with no further delay.
- A pin change held steady reaches `stable`, and sets `chg`, on the (2+`DEBOUNCE_CYCLES`)-th rising edge after the pin changes.
- `irq` is registered: high one cycle after `(chg & mask)` becomes non-zero; low one cycle after it becomes zero.

## Configuration
- `IO_BANK_IRQ_EN` defined:
  - mask register at 0x09 and the `irq` port exist
  - `irq` = registered OR of `chg & mask`
- `IO_BANK_IRQ_EN` undefined:
  - no `irq` port and no mask register
  - 0x09 reads 0 and ignores writes
  - status polling only

## Structure
- Package `io_bank_pkg` holds:
  - address constants `IO_SW_BASE`=0x00, `IO_STATUS`=0x08, `IO_MASK`=0x09, `IO_LED_BASE`=0x10
  - `io_addr_t` (5-bit logic typedef)
- Sub-module `io_debounce`, parametrised by `WIDTH` and `DEBOUNCE_CYCLES`. It contains one bank's synchroniser, counter and stable register, and outputs `stable` plus a one-cycle `changed` pulse. It is instantiated `NUM_CH` times in a generate loop.
- The top level keeps the decode, LED registers, status/mask registers and read mux.

## Test plan
- Reset: hold rst=0 for 3 cycles with switches=8'hff → all outputs 0; read 0x00 → 0.
- Debounce, with `DEBOUNCE_CYCLES`=4: bank 0 driven to 8'h4a → read 0x00 is 0 before the 6th edge and 8'h4a after it; read 0x08 → bit 0 set; a second read of 0x08 → 0.
- Glitch: bank 1 pulses 8'h8b for 3 cycles, then returns to 0 → read 0x01 stays 0; status bit 1 stays 0.
- LEDs: write 0x11 with 32'hdead_00c1 → `leds[1]`=8'hc1 the next cycle; read 0x11 → 8'hc1; write 0x07 (`NUM_CH`=2) → no change anywhere.
- Race: bank 0 change lands on the same edge as a read of 0x08 → the read returns bit 0 clear and the following read returns bit 0 set.
- IRQ (`IO_BANK_IRQ_EN`): mask=0b10, bank 0 changes → `irq` stays 0; bank 1 changes to 8'h70 → `irq`=1 one cycle after the flag sets; read 0x08 → `irq`=0 two cycles later.
